// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a binary source and the BCD converter.
interface bin2bcd_seq_if #(
  parameter int unsigned BIN_W  = 27,
  parameter int unsigned DIGITS = 8
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  valid;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output start, bin,
    input  busy, valid, overflow, bcd
  );

  modport slave (
    input  start, bin,
    output busy, valid, overflow, bcd
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-packed-BCD converter, one shift per clock.
// The result register holds the last conversion so a downstream display stays steady.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 27,
  parameter int unsigned DIGITS = 8,
  parameter int unsigned CNT_W  = 5
) (
  input logic           clk,
  input logic           reset,
  bin2bcd_seq_if.slave  bus
);

  localparam int unsigned BcdW = 4 * DIGITS;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [BIN_W-1:0]  shreg_q, shreg_d;
  logic [BcdW-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              overflow_q, overflow_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [BcdW-1:0]   adj;

  // Add-3 correction: every digit >= 5 gets +3 before the shift, all digits in parallel.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state logic for the conversion sequencer and the result registers.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          shreg_d   = bus.bin;
          scratch_d = '0;
          ovf_d     = 1'b0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = StShift;
        end
      end
      StShift: begin
        scratch_d = {adj[BcdW-2:0], shreg_q[BIN_W-1]};
        shreg_d   = {shreg_q[BIN_W-2:0], 1'b0};
        // A one leaving the top digit means the value no longer fits in DIGITS digits.
        if (adj[BcdW-1]) begin
          ovf_d = 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bcd_d      = ovf_q ? {DIGITS{4'h9}} : scratch_q;
        overflow_d = ovf_q;
        valid_d    = 1'b1;
        busy_d     = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      bcd_q      <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      bcd_q      <= bcd_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = overflow_q;
  assign bus.bcd      = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised self-checking bench for bin2bcd_seq against a cycle-level behavioural model.
module tb_bin2bcd_seq;

  localparam int unsigned BIN_W  = 27;
  localparam int unsigned DIGITS = 8;
  localparam int unsigned LAT    = BIN_W + 1;
  localparam int unsigned MAXDEC = 99_999_999;

  logic clk = 1'b0;
  logic reset;

  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: cycles left in the current conversion, captured input, expected outputs.
  int unsigned m_cnt;
  int unsigned m_val;
  logic [31:0] m_bcd;
  logic        m_ovf;
  logic        m_valid;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Decimal conversion by plain division; saturates above the display range.
  function automatic void model_conv(input int unsigned v, output logic [31:0] b, output logic o);
    int unsigned x;
    x = v;
    b = '0;
    o = 1'b0;
    if (x > MAXDEC) begin
      b = 32'h9999_9999;
      o = 1'b1;
    end else begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        b[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_cnt   = 0;
      m_bcd   = '0;
      m_ovf   = 1'b0;
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_cnt == 0) begin
        if (bus.start) begin
          m_val = int'(bus.bin);
          m_cnt = LAT;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          model_conv(m_val, m_bcd, m_ovf);
          m_valid = 1'b1;
        end
      end
    end
    #1;
    check_eq("busy", 32'(bus.busy), 32'(m_cnt != 0));
    check_eq("valid", 32'(bus.valid), 32'(m_valid));
    check_eq("bcd", bus.bcd, m_bcd);
    check_eq("overflow", 32'(bus.overflow), 32'(m_ovf));
  endtask

  // One isolated conversion followed by a directed check of the final result.
  task automatic run_conv(input int unsigned v, input logic [31:0] exp_bcd, input logic exp_ovf);
    bus.bin   = BIN_W'(v);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (LAT - 1) tick();
    check_eq("pre_valid", 32'(bus.valid), 32'd0);
    tick();
    check_eq("dir_valid", 32'(bus.valid), 32'd1);
    check_eq("dir_bcd", bus.bcd, exp_bcd);
    check_eq("dir_ovf", 32'(bus.overflow), 32'(exp_ovf));
  endtask

  initial begin
    int unsigned r;
    m_cnt     = 0;
    m_val     = 0;
    m_bcd     = '0;
    m_ovf     = 1'b0;
    m_valid   = 1'b0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (2) tick();
    check_eq("rst_bcd", bus.bcd, 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    tick();

    // Directed values, including both sides of the saturation boundary.
    run_conv(0, 32'h0000_0000, 1'b0);
    run_conv(12_345_678, 32'h1234_5678, 1'b0);
    run_conv(99_999_999, 32'h9999_9999, 1'b0);
    run_conv(100_000_000, 32'h9999_9999, 1'b1);
    run_conv(7, 32'h0000_0007, 1'b0);
    run_conv((1 << BIN_W) - 1, 32'h9999_9999, 1'b1);
    repeat (3) tick();
    check_eq("hold_bcd", bus.bcd, 32'h9999_9999);

    // start held high with bin changing every cycle: mid-busy starts and bin changes ignored.
    bus.start = 1'b1;
    for (int i = 0; i < 4 * int'(LAT + 1); i++) begin
      bus.bin = BIN_W'(90_000_000 + i * 3_333_331);
      tick();
    end
    bus.start = 1'b0;
    repeat (LAT + 2) tick();

    // Reset ten cycles into a conversion aborts it.
    bus.bin   = BIN_W'(55_555_555);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_bcd", bus.bcd, 32'h0);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    repeat (LAT + 2) tick();
    check_eq("abort_novalid", 32'(bus.valid), 32'd0);
    run_conv(55_555_555, 32'h5555_5555, 1'b0);

    // Random back-to-back conversions; some draws are steered near the range limit.
    for (int n = 0; n < 1000; n++) begin
      if (n % 8 == 0) r = MAXDEC - 4 + $urandom_range(0, 8);
      else            r = $urandom_range(0, (1 << BIN_W) - 1);
      bus.bin   = BIN_W'(r);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (LAT) tick();
    end
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
